mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_lat_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// region bits of the memory address and the default read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic REGION_INSTR = 1'b0;
  localparam logic REGION_DATA  = 1'b1;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int LAT_CNT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; tracks outstanding memory read latency.
module mem_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an I-cache and a D-cache onto one memory port; ack MEM_LAT+2 cycles after acceptance.
// Data wins ties by default; define MEM_ARB_RR_EN for round-robin on ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int A_WIDTH = 8
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               i_req,
  input  logic [A_WIDTH-1:0] i_addr,
  output logic               i_ack,
  output logic [15:0]        i_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [A_WIDTH-1:0] d_addr,
  input  logic [7:0]         d_wdata,
  output logic               d_ack,
  output logic [7:0]         d_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [A_WIDTH:0]   mem_addr,
  output logic [15:0]        mem_wdata,
  input  logic [15:0]        mem_rdata,
  output logic               busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             wr_q, wr_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [A_WIDTH:0] mem_addr_q, mem_addr_d;
  logic [15:0]      mem_wdata_q, mem_wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             i_ack_q, i_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic             pick_data;
  logic             accept;

  // The ack cycle still sees the finished request's req high, so it is not a new request.
  assign accept = (state_q == ST_IDLE) && (i_req || d_req) && !(i_ack_q || d_ack_q);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  assign pick_data = d_req && (!i_req || (last_q == REGION_INSTR));

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      last_q <= REGION_DATA;
    end else if (accept) begin
      last_q <= pick_data;
    end
  end
`else
  assign pick_data = d_req;
`endif

  mem_lat_counter #(
    .W(LAT_CNT_W)
  ) u_lat_cnt (
    .clk_i      (g_clk),
    .rst_n_i    (g_clr),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_ISSUE;
          grant_d  = pick_data;
          wr_d     = pick_data && d_we;
          mem_en_d = 1'b1;
          mem_we_d = pick_data && d_we;
          if (pick_data) begin
            mem_addr_d  = {REGION_DATA, d_addr};
            mem_wdata_d = {8'h00, d_wdata};
          end else begin
            mem_addr_d  = {REGION_INSTR, i_addr};
            mem_wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        i_ack_d = (grant_q == REGION_INSTR);
        d_ack_d = (grant_q == REGION_DATA);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= ST_IDLE;
      grant_q     <= REGION_DATA;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = rdata_q;
  assign d_rdata   = rdata_q[7:0];
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default-latency instance plus MEM_LAT=1 and MEM_LAT=5 instances.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        g_clr;
  logic        i_req, d_req, d_we, d_req_l1, d_req_l5;
  logic [7:0]  i_addr, d_addr, d_wdata;
  logic [15:0] rval;

  logic        i_ack_m, d_ack_m, mem_en_m, mem_we_m, busy_m;
  logic [15:0] i_rdata_m, mem_wdata_m, rdata_m;
  logic [7:0]  d_rdata_m;
  logic [8:0]  mem_addr_m;

  logic        i_ack_1, d_ack_1, mem_en_1, mem_we_1, busy_1;
  logic [15:0] i_rdata_1, mem_wdata_1, rdata_1;
  logic [7:0]  d_rdata_1;
  logic [8:0]  mem_addr_1;

  logic        i_ack_5, d_ack_5, mem_en_5, mem_we_5, busy_5;
  logic [15:0] i_rdata_5, mem_wdata_5, rdata_5;
  logic [7:0]  d_rdata_5;
  logic [8:0]  mem_addr_5;

  logic [4:0]  pipe_m, pipe_1, pipe_5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .g_clk(clk), .g_clr(g_clr),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_m), .i_rdata(i_rdata_m),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_m), .d_rdata(d_rdata_m),
    .mem_en(mem_en_m), .mem_we(mem_we_m), .mem_addr(mem_addr_m),
    .mem_wdata(mem_wdata_m), .mem_rdata(rdata_m), .busy(busy_m)
  );

  mem_arbiter #(.MEM_LAT(1)) u_lat1 (
    .g_clk(clk), .g_clr(g_clr),
    .i_req(1'b0), .i_addr(8'h00), .i_ack(i_ack_1), .i_rdata(i_rdata_1),
    .d_req(d_req_l1), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_1), .d_rdata(d_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(rdata_1), .busy(busy_1)
  );

  mem_arbiter #(.MEM_LAT(5)) u_lat5 (
    .g_clk(clk), .g_clr(g_clr),
    .i_req(1'b0), .i_addr(8'h00), .i_ack(i_ack_5), .i_rdata(i_rdata_5),
    .d_req(d_req_l5), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack_5), .d_rdata(d_rdata_5),
    .mem_en(mem_en_5), .mem_we(mem_we_5), .mem_addr(mem_addr_5),
    .mem_wdata(mem_wdata_5), .mem_rdata(rdata_5), .busy(busy_5)
  );

  // Memory models: read data is valid only in the cycle MEM_LAT after the mem_en cycle.
  always @(posedge clk or negedge g_clr) begin
    if (!g_clr) begin
      pipe_m <= '0;
      pipe_1 <= '0;
      pipe_5 <= '0;
    end else begin
      pipe_m <= {pipe_m[3:0], mem_en_m & ~mem_we_m};
      pipe_1 <= {pipe_1[3:0], mem_en_1 & ~mem_we_1};
      pipe_5 <= {pipe_5[3:0], mem_en_5 & ~mem_we_5};
    end
  end

  assign rdata_m = pipe_m[1] ? rval : 16'hDEAD;
  assign rdata_1 = pipe_1[0] ? rval : 16'hDEAD;
  assign rdata_5 = pipe_5[4] ? rval : 16'hDEAD;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    int l1, l5;
    int acks_seen;
    logic exp_order [4];
    logic [1:0] exp_ack;

`ifdef MEM_ARB_RR_EN
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`endif

    g_clr = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_req_l1 = 1'b0; d_req_l5 = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; rval = '0;
    tick();
    tick();
    check_eq("rst_mem_en", mem_en_m, 0);
    check_eq("rst_mem_we", mem_we_m, 0);
    check_eq("rst_mem_addr", mem_addr_m, 0);
    check_eq("rst_mem_wdata", mem_wdata_m, 0);
    check_eq("rst_i_ack", i_ack_m, 0);
    check_eq("rst_d_ack", d_ack_m, 0);
    check_eq("rst_busy", busy_m, 0);
    check_eq("rst_i_rdata", i_rdata_m, 0);
    check_eq("rst_d_rdata", d_rdata_m, 0);
    #2 g_clr = 1'b1;
    tick();

    // Instruction read
    i_req = 1'b1; i_addr = 8'h05; rval = 16'hA1B2;
    tick();
    check_eq("ird_mem_en", mem_en_m, 1);
    check_eq("ird_mem_addr", mem_addr_m, 9'h005);
    check_eq("ird_mem_we", mem_we_m, 0);
    check_eq("ird_busy", busy_m, 1);
    cyc = 0;
    while (!i_ack_m && cyc < 20) begin tick(); cyc++; end
    check_eq("ird_latency", cyc, 4);
    check_eq("ird_rdata", i_rdata_m, 16'hA1B2);
    check_eq("ird_no_d_ack", d_ack_m, 0);
    i_req = 1'b0;
    tick();
    check_eq("ird_ack_pulse", i_ack_m, 0);
    check_eq("ird_idle", busy_m, 0);

    // Data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h22; rval = 16'h5A77;
    tick();
    check_eq("drd_mem_addr", mem_addr_m, 9'h122);
    check_eq("drd_mem_we", mem_we_m, 0);
    cyc = 0;
    while (!d_ack_m && cyc < 20) begin tick(); cyc++; end
    check_eq("drd_latency", cyc, 4);
    check_eq("drd_rdata", d_rdata_m, 8'h77);
    d_req = 1'b0;
    tick();

    // Data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h3C; rval = 16'hFFFF;
    tick();
    check_eq("dwr_mem_en", mem_en_m, 1);
    check_eq("dwr_mem_we", mem_we_m, 1);
    check_eq("dwr_mem_addr", mem_addr_m, 9'h110);
    check_eq("dwr_mem_wdata", mem_wdata_m, 16'h003C);
    tick();
    check_eq("dwr_en_one_cycle", mem_en_m, 0);
    check_eq("dwr_we_one_cycle", mem_we_m, 0);
    cyc = 1;
    while (!d_ack_m && cyc < 20) begin tick(); cyc++; end
    check_eq("dwr_latency", cyc, 4);
    check_eq("dwr_rdata_kept", d_rdata_m, 8'h77);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("dwr_ack_pulse", d_ack_m, 0);

    // Both requesters held high for four transactions
    i_req = 1'b1; d_req = 1'b1; i_addr = 8'h01; d_addr = 8'h02; rval = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!mem_en_m && cyc < 20) begin tick(); cyc++; end
      check_eq($sformatf("tie_grant%0d", k), mem_addr_m[8], exp_order[k]);
      cyc = 0;
      while (!(i_ack_m || d_ack_m) && cyc < 20) begin tick(); cyc++; end
      exp_ack = exp_order[k] ? 2'b01 : 2'b10;
      check_eq($sformatf("tie_ack%0d", k), {i_ack_m, d_ack_m}, exp_ack);
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      tick();
    end
    tick();
    check_eq("tie_idle", busy_m, 0);

    // Reset during WAIT
    i_req = 1'b1; i_addr = 8'h07; rval = 16'h4444;
    tick();
    tick();
    check_eq("rstw_busy_before", busy_m, 1);
    #2 g_clr = 1'b0;
    #1;
    check_eq("rstw_mem_en", mem_en_m, 0);
    check_eq("rstw_busy", busy_m, 0);
    check_eq("rstw_acks", {i_ack_m, d_ack_m}, 0);
    i_req = 1'b0;
    tick();
    #2 g_clr = 1'b1;
    acks_seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (i_ack_m || d_ack_m) acks_seen++;
    end
    check_eq("rstw_no_ack", acks_seen, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33; rval = 16'h1234;
    tick();
    cyc = 0;
    while (!d_ack_m && cyc < 20) begin tick(); cyc++; end
    check_eq("rstw_next_latency", cyc, 4);
    check_eq("rstw_next_rdata", d_rdata_m, 8'h34);
    d_req = 1'b0;
    tick();

    // Latency variants
    d_req_l1 = 1'b1; d_req_l5 = 1'b1; d_we = 1'b0; d_addr = 8'h44; rval = 16'h00C7;
    l1 = -1; l5 = -1;
    tick();
    cyc = 0;
    while ((l1 < 0 || l5 < 0) && cyc < 20) begin
      tick();
      cyc++;
      if (d_ack_1 && l1 < 0) begin l1 = cyc; d_req_l1 = 1'b0; end
      if (d_ack_5 && l5 < 0) begin l5 = cyc; d_req_l5 = 1'b0; end
    end
    check_eq("lat1_latency", l1, 3);
    check_eq("lat5_latency", l5, 7);
    check_eq("lat1_rdata", d_rdata_1, 8'hC7);
    check_eq("lat5_rdata", d_rdata_5, 8'hC7);
    tick();
    check_eq("lat_idle", {busy_1, busy_5, i_ack_1, i_ack_5}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
